// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Provides bus widths, the enable/disable encodings, the zero word,
// the fetch FSM state encoding and a word-alignment helper.
package inst_fetch_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_DATA_BUS = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Clear the byte-offset bits so a redirect always lands on a word.
    function automatic logic [INST_ADDR_BUS-1:0] align_word(
        input logic [INST_ADDR_BUS-1:0] addr
    );
        return {addr[INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// The head entry is presented combinationally so the consumer sees it
// in the cycle after the push edge.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   flush          - empties the queue; wins over push/pop on the same edge
//   push/push_data - write one entry at the tail (ignored when full)
//   pop            - remove the head entry (ignored when empty)
//   head_data      - current head entry (undefined content when empty)
//   full, empty    - occupancy flags
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] write_en;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign write_en[gi] = push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en[i]) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks pc through the instruction ROM, buffers
// fetched words in a small queue for decode, and redirects on branches.
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   rom_chip_enable, rom_addr    - ROM request (rom_addr always equals pc)
//   rom_instruction              - combinational ROM read data
//   branch_taken, branch_target  - one-cycle redirect request from execute
//   out_valid/out_ready          - handshake towards decode
//   out_pc, out_instruction      - head of the fetch queue (zero when empty)
//   misaligned                   - pulses the cycle after a redirect whose
//                                  target had nonzero low bits
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                       QUEUE_DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     rom_chip_enable,
    output logic [INST_ADDR_BUS-1:0] rom_addr,
    input  logic [INST_DATA_BUS-1:0] rom_instruction,
    input  logic                     branch_taken,
    input  logic [INST_ADDR_BUS-1:0] branch_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_ADDR_BUS-1:0] out_pc,
    output logic [INST_DATA_BUS-1:0] out_instruction,
    output logic                     misaligned
);

    localparam int QW = INST_ADDR_BUS + INST_DATA_BUS;

    fetch_state_t             state_reg;
    fetch_state_t             state_next;
    logic [INST_ADDR_BUS-1:0] pc_reg;
    logic [INST_ADDR_BUS-1:0] pc_next;
    logic                     misaligned_reg;
    logic                     misaligned_next;

    logic          q_push;
    logic          q_pop;
    logic          q_flush;
    logic          q_full;
    logic          q_empty;
    logic [QW-1:0] q_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            misaligned_reg <= misaligned_next;
        end
    end

    // The ROM enable depends only on state and queue occupancy, never on
    // out_ready, so there is no combinational path from decode to the ROM.
    // A redirect overrides any push/pop of the same cycle.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        misaligned_next = 1'b0;
        rom_chip_enable = DISABLE;
        q_push          = 1'b0;
        q_pop           = 1'b0;
        q_flush         = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                rom_chip_enable = q_full ? DISABLE : ENABLE;
                if (branch_taken) begin
                    q_flush         = 1'b1;
                    pc_next         = align_word(branch_target);
                    misaligned_next = |branch_target[1:0];
                end else begin
                    q_push = (rom_chip_enable == ENABLE);
                    q_pop  = !q_empty && out_ready;
                    if (q_push) begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (q_flush),
        .push      (q_push),
        .push_data ({pc_reg, rom_instruction}),
        .pop       (q_pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign rom_addr        = pc_reg;
    assign misaligned      = misaligned_reg;
    assign out_valid       = !q_empty;
    assign out_pc          = q_empty ? ZERO_WORD : q_head[QW-1 -: INST_ADDR_BUS];
    assign out_instruction = q_empty ? ZERO_WORD : q_head[INST_DATA_BUS-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch, checked cycle by cycle against a
// queue-based reference model. A second instance with a high RESET_PC
// exercises pc wrap-around straight out of reset.
module tb_inst_fetch;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        out_ready = 1'b1;

    logic        rom_chip_enable;
    logic [31:0] rom_addr;
    logic [31:0] rom_instruction;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        misaligned;

    logic        hi_ce;
    logic [31:0] hi_addr;
    logic [31:0] hi_instruction;
    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_out_instruction;
    logic        hi_misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        case (a)
            32'd0:   return 32'd11;
            32'd4:   return 32'd22;
            32'd8:   return 32'd33;
            32'd12:  return 32'd44;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign rom_instruction = rom_fn(rom_addr);
    assign hi_instruction  = rom_fn(hi_addr);

    inst_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rom_chip_enable (rom_chip_enable),
        .rom_addr        (rom_addr),
        .rom_instruction (rom_instruction),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .misaligned      (misaligned)
    );

    inst_fetch #(
        .RESET_PC    (32'hFFFF_FFF8),
        .QUEUE_DEPTH (4)
    ) dut_hi (
        .clock           (clock),
        .reset           (reset),
        .rom_chip_enable (hi_ce),
        .rom_addr        (hi_addr),
        .rom_instruction (hi_instruction),
        .branch_taken    (1'b0),
        .branch_target   (32'h0),
        .out_valid       (hi_valid),
        .out_ready       (1'b1),
        .out_pc          (hi_pc),
        .out_instruction (hi_out_instruction),
        .misaligned      (hi_misaligned)
    );

    // Reference model: running flag, pc, and a queue of fetched entries.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      q_m[$];
    bit          run_m = 1'b0;
    logic [31:0] pc_m = '0;
    bit          mis_m = 1'b0;

    logic [31:0] hi_seen[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit fetch;
        fetch = run_m && (q_m.size() < DEPTH);
        if (reset) begin
            q_m.delete();
            pc_m  = 32'h0;
            run_m = 1'b0;
            mis_m = 1'b0;
        end else if (!run_m) begin
            run_m = 1'b1;
            mis_m = 1'b0;
        end else if (branch_taken) begin
            q_m.delete();
            pc_m  = {branch_target[31:2], 2'b00};
            mis_m = (branch_target[1:0] != 2'b00);
            $display("redirect target=%h", branch_target);
        end else begin
            mis_m = 1'b0;
            if (q_m.size() > 0 && out_ready) begin
                $display("pop pc=%h instr=%h", q_m[0].pc, q_m[0].ins);
                void'(q_m.pop_front());
            end
            if (fetch) begin
                q_m.push_back('{pc_m, rom_fn(pc_m)});
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] epc;
        logic [31:0] eins;
        v    = (q_m.size() != 0);
        epc  = v ? q_m[0].pc : 32'h0;
        eins = v ? q_m[0].ins : 32'h0;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, v});
        check_eq("out_pc", out_pc, epc);
        check_eq("out_instruction", out_instruction, eins);
        check_eq("rom_chip_enable", {31'b0, rom_chip_enable},
                 {31'b0, run_m && (q_m.size() < DEPTH)});
        check_eq("rom_addr", rom_addr, pc_m);
        check_eq("misaligned", {31'b0, misaligned}, {31'b0, mis_m});
    endtask

    task automatic cycle(input logic r, input logic br, input logic [31:0] tgt, input logic rdy);
        reset         = r;
        branch_taken  = br;
        branch_target = tgt;
        out_ready     = rdy;
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_outputs();
    endtask

    // Capture the first three heads delivered by the high-RESET_PC instance.
    always @(negedge clock) begin
        if (!reset && hi_valid && hi_seen.size() < 3) begin
            hi_seen.push_back(hi_pc);
        end
    end

    initial begin
        logic [31:0] hi_exp [3];
        hi_exp[0] = 32'hFFFF_FFF8;
        hi_exp[1] = 32'hFFFF_FFFC;
        hi_exp[2] = 32'h0000_0000;

        // Reset, then streaming with out_ready held high.
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-pressure: queue fills and fetch stalls.
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while two entries are queued.
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect.
        cycle(1'b0, 1'b1, 32'h43, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect near the top of the address space to force a wrap.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF2, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with a full queue, then a branch during IDLE (ignored).
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h80, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        br;
            logic [31:0] tgt;
            logic        rdy;
            r   = ($urandom_range(0, 99) == 0);
            br  = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            cycle(r, br, tgt, rdy);
        end

        check_eq("hi_count", 32'(hi_seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < hi_seen.size(); i++) begin
            check_eq("hi_out_pc", hi_seen[i], hi_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
